gshare_bpb: RTL

Parametrised conditional-branch predictor for the 5-stage MIPS pipeline, and the next generation of the existing `bpb`. It predicts `beq`/`bne` direction and target in Fetch from a table of saturating counters, indexed by PC alone (bimodal) or by PC XOR global history (gshare). It carries each prediction's context into Decode, trains on resolution, and repairs speculative history on a miss. Free-running branch and miss counters provide performance measurement.

---
 rtl/gshare_bpb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gshare_bpb.sv
// Gshare / bimodal conditional-branch predictor for the 5-stage MIPS pipeline.
// Predicts beq/bne in Fetch, trains from Decode resolution, repairs history on a miss.
module gshare_bpb #(
    parameter int INDEX_W = 6,
    parameter int HIST_W  = 6,
    parameter int CNT_W   = 2,
    parameter int MODE    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_f_i,
    input  logic [31:0] instr_f_i,
    input  logic        is_branch_d_i,
    input  logic        miss_i,
    output logic        last_taken_o,
    output logic [31:0] predict_pc_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]   table_q [ENTRIES];
    logic [CNT_W-1:0]   table_d [ENTRIES];
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [HIST_W-1:0]  d_ghr_q, d_ghr_d;
    logic [INDEX_W-1:0] d_idx_q, d_idx_d;
    logic               d_valid_q, d_valid_d;
    logic               d_pred_q, d_pred_d;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] idx_f;
    logic               is_br_f, pred_f, taken_d;
    logic [31:0]        seq_pc, br_target;
    logic [HIST_W-1:0]  ghr_spec, ghr_fix;
    logic               instr_unused;

    assign instr_unused = ^instr_f_i[25:16];
    assign is_br_f = (instr_f_i[31:26] == 6'b000100) || (instr_f_i[31:26] == 6'b000101);

    generate
        if (MODE == 0) begin : g_bimodal
            assign idx_f = pc_f_i[INDEX_W+1:2];
        end else begin : g_gshare
            assign idx_f = pc_f_i[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
        end
    endgenerate

    assign pred_f       = table_q[idx_f][CNT_W-1];
    assign seq_pc       = pc_f_i + 32'd4;
    assign br_target    = seq_pc + {{14{instr_f_i[15]}}, instr_f_i[15:0], 2'b00};
    assign predict_pc_o = (is_br_f && pred_f) ? br_target : seq_pc;

    assign last_taken_o = d_pred_q;
    assign taken_d      = d_pred_q ^ miss_i;
    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // Truncating casts drop the oldest bit; with HIST_W = 1 only the new bit survives.
    assign ghr_spec = HIST_W'({ghr_q, pred_f});
    assign ghr_fix  = HIST_W'({d_ghr_q, taken_d});

    always_comb begin
        table_d      = table_q;
        ghr_d        = ghr_q;
        d_valid_d    = d_valid_q;
        d_idx_d      = d_idx_q;
        d_pred_d     = d_pred_q;
        d_ghr_d      = d_ghr_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (en_i) begin
            if (is_branch_d_i && d_valid_q) begin
                if (taken_d) begin
                    if (table_q[d_idx_q] != CNT_MAX) table_d[d_idx_q] = table_q[d_idx_q] + 1'b1;
                end else begin
                    if (table_q[d_idx_q] != '0) table_d[d_idx_q] = table_q[d_idx_q] - 1'b1;
                end
            end
            if (miss_i) begin
                ghr_d     = ghr_fix;
                d_valid_d = 1'b0;
                d_idx_d   = '0;
                d_pred_d  = 1'b0;
                d_ghr_d   = '0;
            end else begin
                if (is_br_f) ghr_d = ghr_spec;
                d_valid_d = is_br_f;
                d_idx_d   = idx_f;
                d_pred_d  = is_br_f & pred_f;
                d_ghr_d   = ghr_q;
            end
            if (is_branch_d_i) branch_cnt_d = branch_cnt_q + 32'd1;
            if (miss_i)        miss_cnt_d   = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
            ghr_q        <= '0;
            d_valid_q    <= 1'b0;
            d_idx_q      <= '0;
            d_pred_q     <= 1'b0;
            d_ghr_q      <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            table_q      <= table_d;
            ghr_q        <= ghr_d;
            d_valid_q    <= d_valid_d;
            d_idx_q      <= d_idx_d;
            d_pred_q     <= d_pred_d;
            d_ghr_q      <= d_ghr_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule
